// File: rtl/pr_freeze_sequencer_pkg.sv
// Shared types and sizing helpers for the PR freeze sequencer.
// States, default cycle counts and the duration-counter width function.
package pr_freeze_seq_pkg;

   typedef enum logic [2:0] {
      INIT    = 3'd0,
      IDLE    = 3'd1,
      DRAIN   = 3'd2,
      FREEZE  = 3'd3,
      RESET   = 3'd4,
      RELEASE = 3'd5
   } t_frz_state;

   localparam int DEF_DRAIN_TIMEOUT   = 4096;
   localparam int DEF_SETTLE_CYCLES   = 8;
   localparam int DEF_RST_HOLD_CYCLES = 16;

   // One spare bit above the largest count so saturation never masks a terminal value.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/pr_frz_pkt_tracker.sv
// Per-stream packet tracker: remembers whether a Tx stream is between packet beats.
// The clear input (soft reset) wipes any packet cut off by the freeze bridge.
module pr_frz_pkt_tracker (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic tvalid,
   input  logic tready,
   input  logic tlast,
   output logic in_pkt,
   output logic hs_now
);

   logic in_pkt_r;

   assign hs_now = tvalid & tready;
   assign in_pkt = in_pkt_r & ~clr;

   // Packet-open flag: set on a non-last beat, cleared on the last beat or by clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_pkt_r <= 1'b0;
      end else if (clr) begin
         in_pkt_r <= 1'b0;
      end else if (hs_now) begin
         in_pkt_r <= ~tlast;
      end else begin
         in_pkt_r <= in_pkt_r;
      end
   end

endmodule

// File: rtl/pr_freeze_sequencer.sv
// PR freeze sequencer: drains AFU Tx streams, freezes, holds soft reset, then releases.
// Optional drain timeout is enabled by defining PR_FREEZE_TIMEOUT_EN.
module pr_freeze_sequencer
   import pr_freeze_seq_pkg::*;
#(
   parameter int NUM_CH          = 2,
   parameter int DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT,
   parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
   parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pr_start_req,
   input  logic              pr_done,
   input  logic              pr_error,
   input  logic              status_clr,
   input  logic [NUM_CH-1:0] tx_tvalid,
   input  logic [NUM_CH-1:0] tx_tready,
   input  logic [NUM_CH-1:0] tx_tlast,
   output logic              drain_req,
   output logic              pr_freeze,
   output logic              softreset,
   output logic              freeze_ack,
   output logic              busy,
   output logic              sts_timeout,
   output logic              sts_pr_err
);

   localparam int CW = cnt_width(DRAIN_TIMEOUT, SETTLE_CYCLES, RST_HOLD_CYCLES);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

   t_frz_state        state_r;
   t_frz_state        state_nxt_s;
   logic [CW-1:0]     cnt_r;
   logic [NUM_CH-1:0] in_pkt_s;
   logic [NUM_CH-1:0] hs_now_s;
   logic              quiescent_s;
   logic              pr_err_set_s;
   logic              drain_req_r;
   logic              pr_freeze_r;
   logic              softreset_r;
   logic              freeze_ack_r;
   logic              busy_r;
   logic              sts_pr_err_r;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_trk
      pr_frz_pkt_tracker u_trk (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (softreset_r),
         .tvalid (tx_tvalid[i]),
         .tready (tx_tready[i]),
         .tlast  (tx_tlast[i]),
         .in_pkt (in_pkt_s[i]),
         .hs_now (hs_now_s[i])
      );
   end

   assign quiescent_s = ~(|in_pkt_s) & ~(|hs_now_s);

`ifdef PR_FREEZE_TIMEOUT_EN
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);
   logic timeout_set_s;
   logic sts_timeout_r;
`endif

   // Next-state logic; timeout only fires when the drain has not already gone quiet.
   always_comb begin
      state_nxt_s  = state_r;
      pr_err_set_s = 1'b0;
`ifdef PR_FREEZE_TIMEOUT_EN
      timeout_set_s = 1'b0;
`endif
      case (state_r)
         INIT: begin
            if (cnt_r == HOLD_LAST) state_nxt_s = IDLE;
            else                    state_nxt_s = INIT;
         end
         IDLE: begin
            if (pr_start_req) state_nxt_s = DRAIN;
            else              state_nxt_s = IDLE;
         end
         DRAIN: begin
            if (quiescent_s) begin
               state_nxt_s = FREEZE;
`ifdef PR_FREEZE_TIMEOUT_EN
            end else if (cnt_r == DRAIN_LAST) begin
               state_nxt_s   = FREEZE;
               timeout_set_s = 1'b1;
`endif
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         FREEZE: begin
            if (cnt_r == SETTLE_LAST) state_nxt_s = RESET;
            else                      state_nxt_s = FREEZE;
         end
         RESET: begin
            if (pr_done || pr_error) state_nxt_s = RELEASE;
            else                     state_nxt_s = RESET;
            pr_err_set_s = pr_error;
         end
         RELEASE: begin
            if (cnt_r == HOLD_LAST) state_nxt_s = IDLE;
            else                    state_nxt_s = RELEASE;
         end
         default: begin
            state_nxt_s = INIT;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= INIT;
      else        state_r <= state_nxt_s;
   end

   // Duration counter: restarts on every state change and saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (state_nxt_s != state_r) begin
         cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
         cnt_r <= cnt_r + 1'b1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Outputs registered from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_req_r  <= 1'b0;
         pr_freeze_r  <= 1'b0;
         softreset_r  <= 1'b1;
         freeze_ack_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         drain_req_r  <= (state_nxt_s == DRAIN) || (state_nxt_s == FREEZE);
         pr_freeze_r  <= (state_nxt_s == FREEZE) || (state_nxt_s == RESET);
         softreset_r  <= (state_nxt_s == INIT) || (state_nxt_s == RESET) ||
                         (state_nxt_s == RELEASE);
         freeze_ack_r <= (state_nxt_s == RESET);
         busy_r       <= (state_nxt_s != IDLE);
      end
   end

   // Sticky PR error; a set in the same cycle beats the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            sts_pr_err_r <= 1'b0;
      else if (pr_err_set_s) sts_pr_err_r <= 1'b1;
      else if (status_clr)   sts_pr_err_r <= 1'b0;
      else                   sts_pr_err_r <= sts_pr_err_r;
   end

`ifdef PR_FREEZE_TIMEOUT_EN
   // Sticky drain timeout; a set in the same cycle beats the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             sts_timeout_r <= 1'b0;
      else if (timeout_set_s) sts_timeout_r <= 1'b1;
      else if (status_clr)    sts_timeout_r <= 1'b0;
      else                    sts_timeout_r <= sts_timeout_r;
   end
   assign sts_timeout = sts_timeout_r;
`else
   assign sts_timeout = 1'b0;
`endif

   assign drain_req  = drain_req_r;
   assign pr_freeze  = pr_freeze_r;
   assign softreset  = softreset_r;
   assign freeze_ack = freeze_ack_r;
   assign busy       = busy_r;
   assign sts_pr_err = sts_pr_err_r;

endmodule

// File: tb/tb_pr_freeze_sequencer.sv
// Self-checking bench for pr_freeze_sequencer: timing table, corner-case sequences,
// and randomized traffic against an elapsed-time reference model.
module tb_pr_freeze_sequencer;

   localparam int NUM_CH = 2;
   localparam int T_TO   = 4096;
   localparam int T_SET  = 8;
   localparam int T_HOLD = 16;
`ifdef PR_FREEZE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              pr_start_req, pr_done, pr_error, status_clr;
   logic [NUM_CH-1:0] tx_tvalid, tx_tready, tx_tlast;
   logic              drain_req, pr_freeze, softreset, freeze_ack, busy;
   logic              sts_timeout, sts_pr_err;

   int checks   = 0;
   int failures = 0;

   pr_freeze_sequencer #(
      .NUM_CH(NUM_CH), .DRAIN_TIMEOUT(T_TO), .SETTLE_CYCLES(T_SET), .RST_HOLD_CYCLES(T_HOLD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pr_start_req(pr_start_req), .pr_done(pr_done),
      .pr_error(pr_error), .status_clr(status_clr), .tx_tvalid(tx_tvalid),
      .tx_tready(tx_tready), .tx_tlast(tx_tlast), .drain_req(drain_req),
      .pr_freeze(pr_freeze), .softreset(softreset), .freeze_ack(freeze_ack),
      .busy(busy), .sts_timeout(sts_timeout), .sts_pr_err(sts_pr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a phase plus the cycle it was entered; durations are elapsed time.
   typedef enum int {M_INIT, M_IDLE, M_DRAIN, M_FREEZE, M_RESET, M_RELEASE} m_ph_t;
   m_ph_t             m_ph;
   int                m_t;
   int                m_cyc;
   logic [NUM_CH-1:0] m_pkt;
   logic              m_sts_to, m_sts_err;

   function automatic void m_reset();
      m_ph = M_INIT; m_t = 0; m_cyc = 0; m_pkt = '0; m_sts_to = 1'b0; m_sts_err = 1'b0;
   endfunction

   function automatic logic m_sr();
      return (m_ph == M_INIT) || (m_ph == M_RESET) || (m_ph == M_RELEASE);
   endfunction

   function automatic void m_eval();
      logic [NUM_CH-1:0] hs;
      logic  quiet, set_err, set_to;
      int    el;
      m_ph_t nx;
      hs      = tx_tvalid & tx_tready;
      quiet   = (hs == '0) && (m_pkt == '0);
      el      = m_cyc - m_t + 1;
      nx      = m_ph;
      set_err = 1'b0;
      set_to  = 1'b0;
      case (m_ph)
         M_INIT:    if (el >= T_HOLD) nx = M_IDLE;
         M_IDLE:    if (pr_start_req) nx = M_DRAIN;
         M_DRAIN: begin
            if (quiet) nx = M_FREEZE;
            else if (TO_EN && el >= T_TO) begin nx = M_FREEZE; set_to = 1'b1; end
         end
         M_FREEZE:  if (el >= T_SET) nx = M_RESET;
         M_RESET: begin
            if (pr_done || pr_error) nx = M_RELEASE;
            set_err = pr_error;
         end
         M_RELEASE: if (el >= T_HOLD) nx = M_IDLE;
         default:   nx = M_INIT;
      endcase
      if (set_err) m_sts_err = 1'b1; else if (status_clr) m_sts_err = 1'b0;
      if (set_to)  m_sts_to  = 1'b1; else if (status_clr) m_sts_to  = 1'b0;
      for (int i = 0; i < NUM_CH; i++)
         if (m_sr()) m_pkt[i] = 1'b0;
         else if (hs[i]) m_pkt[i] = ~tx_tlast[i];
      if (nx != m_ph) m_t = m_cyc + 1;
      m_ph  = nx;
      m_cyc = m_cyc + 1;
   endfunction

   task automatic chk(input string nm, input logic act, input logic exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      chk("model.drain_req",   drain_req,   (m_ph == M_DRAIN) || (m_ph == M_FREEZE));
      chk("model.pr_freeze",   pr_freeze,   (m_ph == M_FREEZE) || (m_ph == M_RESET));
      chk("model.softreset",   softreset,   m_sr());
      chk("model.freeze_ack",  freeze_ack,  m_ph == M_RESET);
      chk("model.busy",        busy,        m_ph != M_IDLE);
      chk("model.sts_timeout", sts_timeout, m_sts_to);
      chk("model.sts_pr_err",  sts_pr_err,  m_sts_err);
   endtask

   task automatic step();
      m_eval();
      @(posedge clk);
      #1;
      cmp_model();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic set_idle();
      pr_start_req = 1'b0; pr_done = 1'b0; pr_error = 1'b0; status_clr = 1'b0;
      tx_tvalid = '0; tx_tready = '0; tx_tlast = '0;
   endtask

   // ctl = {start, done, error, clr}; exp = {drain_req, pr_freeze, softreset, freeze_ack, busy, sts_pr_err}
   typedef struct {
      int         reps;
      logic [3:0] ctl;
      logic [5:0] exp;
   } vec_t;
   vec_t tbl[23];

   initial begin
      tbl[0]  = '{15, 4'b0000, 6'b001010};
      tbl[1]  = '{1,  4'b0000, 6'b000000};
      tbl[2]  = '{1,  4'b1000, 6'b100010};
      tbl[3]  = '{1,  4'b0000, 6'b110010};
      tbl[4]  = '{7,  4'b0000, 6'b110010};
      tbl[5]  = '{1,  4'b0000, 6'b011110};
      tbl[6]  = '{3,  4'b1000, 6'b011110};
      tbl[7]  = '{1,  4'b0100, 6'b001010};
      tbl[8]  = '{15, 4'b0000, 6'b001010};
      tbl[9]  = '{1,  4'b0000, 6'b000000};
      tbl[10] = '{1,  4'b1000, 6'b100010};
      tbl[11] = '{9,  4'b0000, 6'b011110};
      tbl[12] = '{1,  4'b0011, 6'b001011};
      tbl[13] = '{16, 4'b0000, 6'b000001};
      tbl[14] = '{1,  4'b0001, 6'b000000};
      tbl[15] = '{2,  4'b0100, 6'b000000};
      tbl[16] = '{1,  4'b1100, 6'b100010};
      tbl[17] = '{1,  4'b0000, 6'b110010};
      tbl[18] = '{1,  4'b1000, 6'b110010};
      tbl[19] = '{7,  4'b0000, 6'b011110};
      tbl[20] = '{1,  4'b0010, 6'b001011};
      tbl[21] = '{16, 4'b0000, 6'b000001};
      tbl[22] = '{1,  4'b0001, 6'b000000};

      rst_n = 1'b0;
      set_idle();
      m_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst.softreset",   softreset,   1'b1);
      chk("rst.pr_freeze",   pr_freeze,   1'b0);
      chk("rst.drain_req",   drain_req,   1'b0);
      chk("rst.freeze_ack",  freeze_ack,  1'b0);
      chk("rst.busy",        busy,        1'b0);
      chk("rst.sts_timeout", sts_timeout, 1'b0);
      chk("rst.sts_pr_err",  sts_pr_err,  1'b0);
      rst_n = 1'b1;
      m_reset();

      for (int i = 0; i < 23; i++) begin
         {pr_start_req, pr_done, pr_error, status_clr} = tbl[i].ctl;
         repeat (tbl[i].reps) step();
         chk($sformatf("tbl%0d.drain_req", i),  drain_req,  tbl[i].exp[5]);
         chk($sformatf("tbl%0d.pr_freeze", i),  pr_freeze,  tbl[i].exp[4]);
         chk($sformatf("tbl%0d.softreset", i),  softreset,  tbl[i].exp[3]);
         chk($sformatf("tbl%0d.freeze_ack", i), freeze_ack, tbl[i].exp[2]);
         chk($sformatf("tbl%0d.busy", i),       busy,       tbl[i].exp[1]);
         chk($sformatf("tbl%0d.sts_pr_err", i), sts_pr_err, tbl[i].exp[0]);
      end
      set_idle();

      // Mid-packet drain: stream 1 opens a packet, three beats remain when draining starts.
      tx_tvalid = 2'b10; tx_tready = 2'b10; step();
      tx_tvalid = 2'b00; tx_tready = 2'b00; pr_start_req = 1'b1; step();
      pr_start_req = 1'b0;
      chk("mid.drain_req", drain_req, 1'b1);
      for (int b = 0; b < 3; b++) begin
         tx_tvalid = 2'b10; tx_tready = 2'b10;
         tx_tlast  = (b == 2) ? 2'b10 : 2'b00;
         step();
         chk($sformatf("mid.beat%0d.pr_freeze", b), pr_freeze, 1'b0);
      end
      set_idle();
      step();
      chk("mid.quiet.pr_freeze", pr_freeze, 1'b1);
      run(T_SET);
      chk("mid.freeze_ack", freeze_ack, 1'b1);
      pr_done = 1'b1; step(); pr_done = 1'b0;
      chk("mid.done.pr_freeze", pr_freeze, 1'b0);
      chk("mid.done.softreset", softreset, 1'b1);
      run(T_HOLD - 1);
      chk("mid.hold.softreset", softreset, 1'b1);
      step();
      chk("mid.rel.softreset", softreset, 1'b0);
      chk("mid.rel.busy",      busy,      1'b0);

      // Stream 0 stalls mid-packet through the drain.
      tx_tvalid = 2'b01; tx_tready = 2'b01; step();
      tx_tready = 2'b00; pr_start_req = 1'b1; step();
      pr_start_req = 1'b0;
`ifdef PR_FREEZE_TIMEOUT_EN
      run(T_TO - 1);
      chk("to.before.pr_freeze",   pr_freeze,   1'b0);
      chk("to.before.sts_timeout", sts_timeout, 1'b0);
      step();
      chk("to.hit.pr_freeze",   pr_freeze,   1'b1);
      chk("to.hit.sts_timeout", sts_timeout, 1'b1);
      set_idle();
      run(T_SET);
      pr_done = 1'b1; step(); pr_done = 1'b0;
      run(T_HOLD);
      status_clr = 1'b1; step(); status_clr = 1'b0;
      chk("to.clr.sts_timeout", sts_timeout, 1'b0);
`else
      run(10000);
      chk("stall.drain_req",   drain_req,   1'b1);
      chk("stall.pr_freeze",   pr_freeze,   1'b0);
      chk("stall.busy",        busy,        1'b1);
      chk("stall.sts_timeout", sts_timeout, 1'b0);
      tx_tready = 2'b01; tx_tlast = 2'b01; step();
      chk("stall.last.pr_freeze", pr_freeze, 1'b0);
      set_idle(); step();
      chk("stall.quiet.pr_freeze", pr_freeze, 1'b1);
      run(T_SET);
      pr_done = 1'b1; step(); pr_done = 1'b0;
      run(T_HOLD);
`endif
      chk("stall.idle.busy", busy, 1'b0);

      // Start ignored in FREEZE, then asynchronous reset while in RESET.
      pr_start_req = 1'b1; step(); pr_start_req = 1'b0; step();
      pr_start_req = 1'b1; step(); pr_start_req = 1'b0;
      chk("t6.ign.pr_freeze", pr_freeze, 1'b1);
      chk("t6.ign.drain_req", drain_req, 1'b1);
      run(T_SET - 1);
      chk("t6.in_reset.freeze_ack", freeze_ack, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6.async.pr_freeze",  pr_freeze,  1'b0);
      chk("t6.async.softreset",  softreset,  1'b1);
      chk("t6.async.freeze_ack", freeze_ack, 1'b0);
      chk("t6.async.busy",       busy,       1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_reset();
      run(T_HOLD - 1);
      chk("t6.init.softreset", softreset, 1'b1);
      step();
      chk("t6.idle.softreset", softreset, 1'b0);

      // Randomized traffic and control pulses against the model.
      for (int i = 0; i < 3000; i++) begin
         pr_start_req = ($urandom_range(7) == 0);
         pr_done      = ($urandom_range(15) == 0);
         pr_error     = ($urandom_range(31) == 0);
         status_clr   = ($urandom_range(15) == 0);
         tx_tvalid    = NUM_CH'($urandom);
         tx_tready    = NUM_CH'($urandom);
         tx_tlast     = NUM_CH'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
